// File: rtl/pipe_pkg.sv
// Shared constants and types for all pipeline stages: occupancy type plus
// default payload width and reset value.
package pipe_pkg;

  typedef logic [1:0] occ_t;

  localparam int unsigned PIPE_WIDTH   = 32;
  localparam logic [255:0] PIPE_RST_VAL = '0;

  function automatic occ_t occ_count(input logic main_v, input logic skid_v);
    return occ_t'(main_v) + occ_t'(skid_v);
  endfunction

endpackage

// File: rtl/pipe_slot.sv
// One payload register with its valid bit. Valid follows valid_i every cycle;
// payload only changes on load_i, so clearing valid leaves the payload intact.
module pipe_slot
  import pipe_pkg::*;
#(
  parameter int unsigned      WIDTH   = PIPE_WIDTH,
  parameter logic [WIDTH-1:0] RST_VAL = WIDTH'(PIPE_RST_VAL)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             valid_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o
);

  logic             valid_q;
  logic [WIDTH-1:0] data_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= 1'b0;
      data_q  <= RST_VAL;
    end else begin
      valid_q <= valid_i;
      if (load_i) begin
        data_q <= data_i;
      end
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

// File: rtl/pipe_stage_buf.sv
// Registered pipeline stage buffer. Define PIPE_STAGE_SKID_EN for a two-entry
// skid build (registered in_ready); otherwise a single entry with pass-through ready.
module pipe_stage_buf
  import pipe_pkg::*;
#(
  parameter int unsigned      WIDTH   = PIPE_WIDTH,
  parameter logic [WIDTH-1:0] RST_VAL = WIDTH'(PIPE_RST_VAL)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       occupancy
);

  logic             accept;
  logic             consume;
  logic             main_v_q;
  logic             main_v_d;
  logic             main_ld;
  logic [WIDTH-1:0] main_dat_q;
  logic [WIDTH-1:0] main_dat_d;
  occ_t             occ_q;
  occ_t             occ_d;

  assign accept  = in_valid & in_ready & ~flush;
  assign consume = main_v_q & out_ready;

  pipe_slot #(
    .WIDTH   (WIDTH),
    .RST_VAL (RST_VAL)
  ) u_main (
    .clk     (clk),
    .rst     (rst),
    .load_i  (main_ld),
    .data_i  (main_dat_d),
    .valid_i (main_v_d),
    .valid_o (main_v_q),
    .data_o  (main_dat_q)
  );

`ifdef PIPE_STAGE_SKID_EN
  logic             skid_v_q;
  logic             skid_v_d;
  logic             skid_ld;
  logic [WIDTH-1:0] skid_dat_q;

  pipe_slot #(
    .WIDTH   (WIDTH),
    .RST_VAL (RST_VAL)
  ) u_skid (
    .clk     (clk),
    .rst     (rst),
    .load_i  (skid_ld),
    .data_i  (in_data),
    .valid_i (skid_v_d),
    .valid_o (skid_v_q),
    .data_o  (skid_dat_q)
  );

  // Skid only fills while main is stalled, so it is empty whenever main is.
  assign in_ready = ~skid_v_q;

  always_comb begin
    main_v_d   = main_v_q;
    main_ld    = 1'b0;
    main_dat_d = in_data;
    skid_v_d   = skid_v_q;
    skid_ld    = 1'b0;
    if (flush) begin
      main_v_d = 1'b0;
      skid_v_d = 1'b0;
    end else if (consume) begin
      if (skid_v_q) begin
        main_ld    = 1'b1;
        main_dat_d = skid_dat_q;
        skid_v_d   = 1'b0;
      end else if (accept) begin
        main_ld = 1'b1;
      end else begin
        main_v_d = 1'b0;
      end
    end else if (accept) begin
      if (!main_v_q) begin
        main_ld  = 1'b1;
        main_v_d = 1'b1;
      end else begin
        skid_ld  = 1'b1;
        skid_v_d = 1'b1;
      end
    end
  end

  assign occ_d = occ_count(main_v_d, skid_v_d);
`else
  assign in_ready = ~main_v_q | out_ready;

  always_comb begin
    main_v_d   = main_v_q;
    main_ld    = 1'b0;
    main_dat_d = in_data;
    if (flush) begin
      main_v_d = 1'b0;
    end else if (accept) begin
      main_ld  = 1'b1;
      main_v_d = 1'b1;
    end else if (consume) begin
      main_v_d = 1'b0;
    end
  end

  assign occ_d = occ_count(main_v_d, 1'b0);
`endif

  // Occupancy kept in its own register so the output is never derived from in_*.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      occ_q <= '0;
    end else begin
      occ_q <= occ_d;
    end
  end

  assign out_valid = main_v_q;
  assign out_data  = main_dat_q;
  assign occupancy = occ_q;

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Scoreboard bench for pipe_stage_buf; adapts to either build of PIPE_STAGE_SKID_EN.
module tb_pipe_stage_buf;

  localparam logic [31:0] RSTV = 32'h0000_1234;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [1:0]  occupancy;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] sb[$];

  pipe_stage_buf #(
    .WIDTH   (32),
    .RST_VAL (RSTV)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .occupancy (occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every live output must match the oldest expected entry.
  always @(negedge clk) begin
    if (rst && out_valid) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_out: got %h required no valid output", out_data);
      end else begin
        chk("out_data", out_data, sb[0]);
        if (out_ready && !flush) void'(sb.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; flush = 1'b0; in_valid = 1'b1; in_data = 32'hDEADBEEF; out_ready = 1'b0;
    repeat (3) step();
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data",  out_data, RSTV);
    chk("rst_occ",       32'(occupancy), 32'd0);
    chk("rst_in_ready",  32'(in_ready), 32'd1);

    // First accept on the first edge after release
    rst = 1'b1; out_ready = 1'b1; in_valid = 1'b1; in_data = 32'h42; sb.push_back(32'h42);
    step();
    chk("first_out_valid", 32'(out_valid), 32'd1);
    chk("first_out_data",  out_data, 32'h42);
    chk("first_occ",       32'(occupancy), 32'd1);

    for (int i = 1; i <= 4; i++) begin
      in_data = 32'(i);
      sb.push_back(32'(i));
      step();
      chk("stream_data", out_data, 32'(i));
      chk("stream_occ",  32'(occupancy), 32'd1);
    end
    in_valid = 1'b0;
    step();
    chk("stream_drain_occ", 32'(occupancy), 32'd0);
    chk("stream_drain_vld", 32'(out_valid), 32'd0);

`ifdef PIPE_STAGE_SKID_EN
    out_ready = 1'b0; in_valid = 1'b1; in_data = 32'hA; sb.push_back(32'hA);
    step();
    chk("bp_occ1",   32'(occupancy), 32'd1);
    chk("bp_rdy1",   32'(in_ready), 32'd1);
    in_data = 32'hB; sb.push_back(32'hB);
    step();
    chk("bp_occ2",   32'(occupancy), 32'd2);
    chk("bp_rdy2",   32'(in_ready), 32'd0);
    chk("bp_data_a", out_data, 32'hA);
    in_valid = 1'b0;
    repeat (2) step();
    chk("bp_hold_data", out_data, 32'hA);
    chk("bp_hold_occ",  32'(occupancy), 32'd2);
    out_ready = 1'b1;
    step();
    chk("bp_rel_occ1",  32'(occupancy), 32'd1);
    chk("bp_rel_data",  out_data, 32'hB);
    step();
    chk("bp_rel_occ0",  32'(occupancy), 32'd0);
    chk("bp_rel_vld",   32'(out_valid), 32'd0);
`else
    out_ready = 1'b0; in_valid = 1'b1; in_data = 32'h5; sb.push_back(32'h5);
    step();
    chk("bp_occ1", 32'(occupancy), 32'd1);
    chk("bp_rdy0", 32'(in_ready), 32'd0);
    in_data = 32'h6;
    repeat (2) step();
    chk("bp_hold_data", out_data, 32'h5);
    chk("bp_hold_occ",  32'(occupancy), 32'd1);
    in_valid = 1'b0; out_ready = 1'b1;
    step();
    chk("bp_rel_occ0", 32'(occupancy), 32'd0);
`endif

    // Flush collides with accept and consume
    out_ready = 1'b0; in_valid = 1'b1; in_data = 32'hC1; sb.push_back(32'hC1);
    step();
`ifdef PIPE_STAGE_SKID_EN
    in_data = 32'hC2; sb.push_back(32'hC2);
    step();
    chk("fl_pre_occ", 32'(occupancy), 32'd2);
`else
    chk("fl_pre_occ", 32'(occupancy), 32'd1);
`endif
    flush = 1'b1; in_valid = 1'b1; in_data = 32'h77; out_ready = 1'b1;
    step();
    sb.delete();
    flush = 1'b0; in_valid = 1'b0;
    chk("fl_vld",     32'(out_valid), 32'd0);
    chk("fl_occ",     32'(occupancy), 32'd0);
    chk("fl_payload", out_data, 32'hC1);
    repeat (3) step();
    chk("fl_post_vld", 32'(out_valid), 32'd0);

    // Asynchronous reset between edges with one entry held
    out_ready = 1'b0; in_valid = 1'b1; in_data = 32'h99; sb.push_back(32'h99);
    step();
    in_valid = 1'b0;
    chk("ar_pre_occ", 32'(occupancy), 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("ar_vld",   32'(out_valid), 32'd0);
    chk("ar_occ",   32'(occupancy), 32'd0);
    chk("ar_data",  out_data, RSTV);
    chk("ar_ready", 32'(in_ready), 32'd1);
    sb.delete();
    #3 rst = 1'b1;
    out_ready = 1'b1;
    repeat (3) step();
    chk("ar_post_vld", 32'(out_valid), 32'd0);

    in_valid = 1'b1; in_data = 32'h55; sb.push_back(32'h55);
    step();
    chk("rec_data", out_data, 32'h55);
    in_valid = 1'b0;
    step();
    chk("rec_occ", 32'(occupancy), 32'd0);
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
